// File: rtl/wb_port_arbiter.sv
// Two-writer arbiter for the register-file write port: pipeline writeback vs. MDU result.
// Pipeline has priority; a starvation counter forces one MDU grant (with a one-cycle pipe stall).
module wb_port_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pipe_wd,
    input  logic              pipe_wreg,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_wd,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    output logic              pipe_stall,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_src
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        pipe_req, same_reg;
    logic        grant_pipe, grant_mdu, ready_int;

    assign pipe_req  = pipe_wreg && (pipe_wd != '0);
    assign same_reg  = pipe_req && mdu_valid && (pipe_wd == mdu_wd);
    assign mdu_ready = rst_n && ready_int;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        grant_pipe   = 1'b0;
        grant_mdu    = 1'b0;
        ready_int    = 1'b0;
        case (state)
            IDLE: begin
                if (same_reg) begin
                    // Younger pipeline write to the same register supersedes the MDU result.
                    grant_pipe = 1'b1;
                    ready_int  = 1'b1;
                end else if (mdu_valid && !pipe_req) begin
                    grant_mdu = 1'b1;
                    ready_int = 1'b1;
                end else if (mdu_valid) begin
                    grant_pipe   = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 4'd1;
                end else begin
                    grant_pipe = pipe_req;
                end
            end
            WAIT: begin
                if (!mdu_valid) begin
                    grant_pipe   = pipe_req;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (same_reg) begin
                    grant_pipe   = 1'b1;
                    ready_int    = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (!pipe_req) begin
                    grant_mdu    = 1'b1;
                    ready_int    = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (wait_cnt >= 4'(STARVE_MAX - 1)) begin
                    grant_pipe = 1'b1;
                    state_nxt  = FORCE;
                end else begin
                    grant_pipe   = 1'b1;
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            FORCE: begin
                // Pipeline is stalled this cycle, so its inputs are ignored.
                grant_mdu    = mdu_valid;
                ready_int    = 1'b1;
                state_nxt    = IDLE;
                wait_cnt_nxt = 4'd0;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            pipe_stall <= 1'b0;
            wb_wd      <= '0;
            wb_wreg    <= 1'b0;
            wb_wdata   <= '0;
            wb_src     <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            pipe_stall <= (state_nxt == FORCE);
            wb_wreg    <= 1'b0;
            if (grant_pipe) begin
                wb_wd    <= pipe_wd;
                wb_wdata <= pipe_wdata;
                wb_src   <= 1'b0;
                wb_wreg  <= 1'b1;
            end else if (grant_mdu) begin
                // An MDU result for x0 is consumed but never written.
                wb_wd    <= mdu_wd;
                wb_wdata <= mdu_wdata;
                wb_src   <= 1'b1;
                wb_wreg  <= (mdu_wd != '0);
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: each step's expected write-port result is queued when driven.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  pipe_wd;
    logic        pipe_wreg;
    logic [63:0] pipe_wdata;
    logic        mdu_valid;
    logic [4:0]  mdu_wd;
    logic [63:0] mdu_wdata;
    logic        mdu_ready;
    logic        pipe_stall;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [63:0] wb_wdata;
    logic        wb_src;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.ADDR_W(5), .DATA_W(64), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wd(pipe_wd), .pipe_wreg(pipe_wreg), .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid), .mdu_wd(mdu_wd), .mdu_wdata(mdu_wdata),
        .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .wb_src(wb_src)
    );

    // Stimulus + expectation per cycle: er = mdu_ready this cycle; ew..est = outputs after the edge;
    // ef = also check wb_wd/wb_wdata/wb_src (written or held values).
    typedef struct {
        logic pv; logic [4:0] pwd; logic [63:0] pdat;
        logic mv; logic [4:0] mwd; logic [63:0] mdat;
        logic er;
        logic ew; logic [4:0] ewd; logic [63:0] edat; logic esrc; logic est; logic ef;
    } step_t;

    step_t sb[$];

    task automatic drive(input step_t s);
        @(negedge clk);
        pipe_wreg  = s.pv;  pipe_wd = s.pwd; pipe_wdata = s.pdat;
        mdu_valid  = s.mv;  mdu_wd  = s.mwd; mdu_wdata  = s.mdat;
        sb.push_back(s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pipe_wreg = 1'b1; pipe_wd = 5'd3; pipe_wdata = 64'hFF;
        mdu_valid = 1'b1; mdu_wd = 5'd7; mdu_wdata = 64'hEE;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL reset mdu_ready got %b want 0", mdu_ready); end
        n_cmp++; if (wb_wreg !== 1'b0 || pipe_stall !== 1'b0 || wb_src !== 1'b0) begin
            n_bad++; $display("FAIL reset ctrl got wreg=%b stall=%b src=%b want 0/0/0", wb_wreg, pipe_stall, wb_src);
        end
        n_cmp++; if (wb_wd !== 5'd0 || wb_wdata !== 64'd0) begin
            n_bad++; $display("FAIL reset data got wd=%0d wdata=%h want 0/0", wb_wd, wb_wdata);
        end
        @(negedge clk);
        pipe_wreg = 1'b0; pipe_wd = '0; pipe_wdata = '0;
        mdu_valid = 1'b0; mdu_wd = '0;  mdu_wdata = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_only();
        step_t t[4];
        step_t e;
        t[0] = '{1, 5'd3, 64'hA5, 0, 5'd0, 64'h0, 0,  1, 5'd3, 64'hA5, 0, 0, 1};
        t[1] = '{0, 5'd0, 64'h0,  0, 5'd0, 64'h0, 0,  0, 5'd3, 64'hA5, 0, 0, 1};
        t[2] = '{1, 5'd0, 64'hFF, 0, 5'd0, 64'h0, 0,  0, 5'd3, 64'hA5, 0, 0, 1};
        t[3] = '{1, 5'd31, 64'h5A, 0, 5'd0, 64'h0, 0, 1, 5'd31, 64'h5A, 0, 0, 1};
        foreach (t[i]) begin
            drive(t[i]); #1;
            n_cmp++; if (mdu_ready !== sb[0].er) begin n_bad++; $display("FAIL pipe_only[%0d] mdu_ready got %b want %b", i, mdu_ready, sb[0].er); end
            @(posedge clk); #1; e = sb.pop_front();
            n_cmp++; if (wb_wreg !== e.ew || pipe_stall !== e.est) begin
                n_bad++; $display("FAIL pipe_only[%0d] wreg/stall got %b/%b want %b/%b", i, wb_wreg, pipe_stall, e.ew, e.est);
            end
            if (e.ef) begin
                n_cmp++; if (wb_wd !== e.ewd || wb_wdata !== e.edat || wb_src !== e.esrc) begin
                    n_bad++; $display("FAIL pipe_only[%0d] fields got %0d/%h/%b want %0d/%h/%b", i, wb_wd, wb_wdata, wb_src, e.ewd, e.edat, e.esrc);
                end
            end
        end
    endtask

    task automatic test_mdu_only();
        step_t t[2];
        step_t e;
        t[0] = '{0, 5'd0, 64'h0, 1, 5'd7, 64'h10, 1,  1, 5'd7, 64'h10, 1, 0, 1};
        t[1] = '{0, 5'd0, 64'h0, 0, 5'd0, 64'h0,  0,  0, 5'd7, 64'h10, 1, 0, 1};
        foreach (t[i]) begin
            drive(t[i]); #1;
            n_cmp++; if (mdu_ready !== sb[0].er) begin n_bad++; $display("FAIL mdu_only[%0d] mdu_ready got %b want %b", i, mdu_ready, sb[0].er); end
            @(posedge clk); #1; e = sb.pop_front();
            n_cmp++; if (wb_wreg !== e.ew || pipe_stall !== e.est) begin
                n_bad++; $display("FAIL mdu_only[%0d] wreg/stall got %b/%b want %b/%b", i, wb_wreg, pipe_stall, e.ew, e.est);
            end
            n_cmp++; if (wb_wd !== e.ewd || wb_wdata !== e.edat || wb_src !== e.esrc) begin
                n_bad++; $display("FAIL mdu_only[%0d] fields got %0d/%h/%b want %0d/%h/%b", i, wb_wd, wb_wdata, wb_src, e.ewd, e.edat, e.esrc);
            end
        end
    endtask

    task automatic test_starve();
        step_t t[6];
        step_t e;
        t[0] = '{1, 5'd1, 64'h11, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h11, 0, 0, 1};
        t[1] = '{1, 5'd1, 64'h12, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h12, 0, 0, 1};
        t[2] = '{1, 5'd1, 64'h13, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h13, 0, 0, 1};
        t[3] = '{1, 5'd1, 64'h14, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h14, 0, 1, 1};
        t[4] = '{1, 5'd1, 64'h15, 1, 5'd9, 64'h99, 1,  1, 5'd9, 64'h99, 1, 0, 1};
        t[5] = '{1, 5'd1, 64'h15, 0, 5'd0, 64'h0,  0,  1, 5'd1, 64'h15, 0, 0, 1};
        foreach (t[i]) begin
            drive(t[i]); #1;
            n_cmp++; if (mdu_ready !== sb[0].er) begin n_bad++; $display("FAIL starve[%0d] mdu_ready got %b want %b", i, mdu_ready, sb[0].er); end
            @(posedge clk); #1; e = sb.pop_front();
            n_cmp++; if (wb_wreg !== e.ew || pipe_stall !== e.est) begin
                n_bad++; $display("FAIL starve[%0d] wreg/stall got %b/%b want %b/%b", i, wb_wreg, pipe_stall, e.ew, e.est);
            end
            n_cmp++; if (wb_wd !== e.ewd || wb_wdata !== e.edat || wb_src !== e.esrc) begin
                n_bad++; $display("FAIL starve[%0d] fields got %0d/%h/%b want %0d/%h/%b", i, wb_wd, wb_wdata, wb_src, e.ewd, e.edat, e.esrc);
            end
        end
    endtask

    task automatic test_conflict();
        step_t t[5];
        step_t e;
        t[0] = '{1, 5'd5, 64'h1, 1, 5'd5,  64'h2,  1,  1, 5'd5,  64'h1,  0, 0, 1};
        t[1] = '{0, 5'd0, 64'h0, 0, 5'd0,  64'h0,  0,  0, 5'd5,  64'h1,  0, 0, 1};
        t[2] = '{1, 5'd6, 64'h6, 1, 5'd8,  64'h4,  0,  1, 5'd6,  64'h6,  0, 0, 1};
        t[3] = '{1, 5'd8, 64'h3, 1, 5'd8,  64'h4,  1,  1, 5'd8,  64'h3,  0, 0, 1};
        t[4] = '{0, 5'd0, 64'h0, 1, 5'd10, 64'hAA, 1,  1, 5'd10, 64'hAA, 1, 0, 1};
        foreach (t[i]) begin
            drive(t[i]); #1;
            n_cmp++; if (mdu_ready !== sb[0].er) begin n_bad++; $display("FAIL conflict[%0d] mdu_ready got %b want %b", i, mdu_ready, sb[0].er); end
            @(posedge clk); #1; e = sb.pop_front();
            n_cmp++; if (wb_wreg !== e.ew || pipe_stall !== e.est) begin
                n_bad++; $display("FAIL conflict[%0d] wreg/stall got %b/%b want %b/%b", i, wb_wreg, pipe_stall, e.ew, e.est);
            end
            n_cmp++; if (wb_wd !== e.ewd || wb_wdata !== e.edat || wb_src !== e.esrc) begin
                n_bad++; $display("FAIL conflict[%0d] fields got %0d/%h/%b want %0d/%h/%b", i, wb_wd, wb_wdata, wb_src, e.ewd, e.edat, e.esrc);
            end
        end
    endtask

    task automatic test_x0();
        step_t t[4];
        step_t e;
        t[0] = '{1, 5'd0, 64'hFF, 1, 5'd4, 64'h44, 1,  1, 5'd4, 64'h44, 1, 0, 1};
        t[1] = '{0, 5'd0, 64'h0,  1, 5'd0, 64'h55, 1,  0, 5'd0, 64'h0,  0, 0, 0};
        t[2] = '{1, 5'd0, 64'h77, 0, 5'd0, 64'h0,  0,  0, 5'd0, 64'h0,  0, 0, 0};
        t[3] = '{0, 5'd0, 64'h0,  0, 5'd0, 64'h0,  0,  0, 5'd0, 64'h0,  0, 0, 0};
        foreach (t[i]) begin
            drive(t[i]); #1;
            n_cmp++; if (mdu_ready !== sb[0].er) begin n_bad++; $display("FAIL x0[%0d] mdu_ready got %b want %b", i, mdu_ready, sb[0].er); end
            @(posedge clk); #1; e = sb.pop_front();
            n_cmp++; if (wb_wreg !== e.ew || pipe_stall !== e.est) begin
                n_bad++; $display("FAIL x0[%0d] wreg/stall got %b/%b want %b/%b", i, wb_wreg, pipe_stall, e.ew, e.est);
            end
            if (e.ef) begin
                n_cmp++; if (wb_wd !== e.ewd || wb_wdata !== e.edat || wb_src !== e.esrc) begin
                    n_bad++; $display("FAIL x0[%0d] fields got %0d/%h/%b want %0d/%h/%b", i, wb_wd, wb_wdata, wb_src, e.ewd, e.edat, e.esrc);
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        step_t t[8];
        step_t e;
        t[0] = '{1, 5'd1, 64'h31, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h31, 0, 0, 1};
        t[1] = '{1, 5'd1, 64'h32, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h32, 0, 0, 1};
        t[2] = '{1, 5'd1, 64'h21, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h21, 0, 0, 1};
        t[3] = '{1, 5'd1, 64'h22, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h22, 0, 0, 1};
        t[4] = '{1, 5'd1, 64'h23, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h23, 0, 0, 1};
        t[5] = '{1, 5'd1, 64'h24, 1, 5'd9, 64'h99, 0,  1, 5'd1, 64'h24, 0, 1, 1};
        t[6] = '{1, 5'd1, 64'h25, 1, 5'd9, 64'h99, 1,  1, 5'd9, 64'h99, 1, 0, 1};
        t[7] = '{0, 5'd0, 64'h0,  0, 5'd0, 64'h0,  0,  0, 5'd9, 64'h99, 1, 0, 1};
        foreach (t[i]) begin
            if (i == 2) begin
                // Now in WAIT with wait_cnt==2: reset while the MDU result is still pending.
                @(negedge clk);
                rst_n = 1'b0; #1;
                n_cmp++; if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wait mdu_ready got %b want 0", mdu_ready); end
                @(posedge clk); #1;
                n_cmp++; if (wb_wreg !== 1'b0 || pipe_stall !== 1'b0 || wb_src !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 64'd0) begin
                    n_bad++; $display("FAIL rst_wait outputs got wreg=%b stall=%b src=%b wd=%0d wdata=%h want all 0", wb_wreg, pipe_stall, wb_src, wb_wd, wb_wdata);
                end
                rst_n = 1'b1;
            end
            drive(t[i]); #1;
            n_cmp++; if (mdu_ready !== sb[0].er) begin n_bad++; $display("FAIL rst_wait[%0d] mdu_ready got %b want %b", i, mdu_ready, sb[0].er); end
            @(posedge clk); #1; e = sb.pop_front();
            n_cmp++; if (wb_wreg !== e.ew || pipe_stall !== e.est) begin
                n_bad++; $display("FAIL rst_wait[%0d] wreg/stall got %b/%b want %b/%b", i, wb_wreg, pipe_stall, e.ew, e.est);
            end
            n_cmp++; if (wb_wd !== e.ewd || wb_wdata !== e.edat || wb_src !== e.esrc) begin
                n_bad++; $display("FAIL rst_wait[%0d] fields got %0d/%h/%b want %0d/%h/%b", i, wb_wd, wb_wdata, wb_src, e.ewd, e.edat, e.esrc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_mdu_only();
        test_starve();
        test_conflict();
        test_x0();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
